fir_output_serializer: RTL and testbench
========================================

# fir_output_serializer

Collects the four parallel output samples produced each block by the unfolded/parallel FIR and streams them out one sample per clock, in lane order 0,1,2,3. Each sample is requantized from the FIR's full-precision width to a narrow output width using round-half-up and saturation. The block sits after the FIR core and drives a single-lane consumer such as a DAC interface or capture buffer. It has a 2-block buffer, so it sustains one input block every 4 cycles with no bubbles.

## Interface

Parameters:
- NB_DATA_IN, 19, width of each signed input sample (FIR output width)
- NB_DATA_OUT, 8, width of the signed output sample
- SHIFT, 11, LSBs dropped by requantization; legal range 0 ≤ SHIFT < NB_DATA_IN

Ports:
- clock, in, 1, single clock; all logic is rising-edge
- i_reset, in, 1, asynchronous, active-high reset
- i_enable, in, 1, global enable; when low, all state is frozen
- i_data_0..i_data_3, in, NB_DATA_IN each, signed lane samples; lane 0 is the oldest in time
- i_valid, in, 1, an input block is present
- o_ready, out, 1, the block can accept an input block
- o_data, out, NB_DATA_OUT, signed requantized sample
- o_valid, out, 1, o_data is valid
- i_ready, in, 1, the downstream consumer accepts o_data
- o_sat, out, 1, the current o_data was saturated; qualified by o_valid
- o_last, out, 1, the current o_data is lane 3 of its block; qualified by o_valid

## Operation

- **Handshakes.**
  - Input handshake = i_valid & o_ready & i_enable.
  - Output handshake = o_valid & i_ready & i_enable.
- **Requantization.** Performed at input capture, per lane, in NB_DATA_IN+1 bits:
  - t = x + 2^(SHIFT-1), then y = t >>> SHIFT (arithmetic shift).
  - When SHIFT=0, y = x with no rounding term.
  - If y > 2^(NB_DATA_OUT-1)-1, clamp to that value. If y < -2^(NB_DATA_OUT-1), clamp to that value. Set the lane's stored sat flag when either clamp applies.
  - Stored per lane: NB_DATA_OUT data bits + 1 sat bit.
- **Storage.**
  - Two block registers, ACTIVE and NEXT, each with a full flag.
  - A 2-bit lane counter indexes ACTIVE.
- **Output path.**
  - o_valid = ACTIVE full & i_enable.
  - o_data, o_sat = ACTIVE[lane].
  - o_last = (lane == 3).
  - On an output handshake, lane increments. When lane 3 is accepted, lane wraps to 0 and ACTIVE empties, unless it is refilled the same cycle.
- **Input readiness.** o_ready = ~NEXT full & i_enable & ~i_reset.
- **Input routing on an input handshake:**
  - ACTIVE empty → write to ACTIVE.
  - ACTIVE finishing (lane-3 output handshake this cycle) and NEXT empty → write to ACTIVE.
  - Otherwise → write to NEXT.
- **NEXT→ACTIVE transfer.** When lane 3 is accepted and NEXT is full, NEXT moves to ACTIVE, NEXT empties, and lane resets to 0. While NEXT is full, o_ready=0, so no input can collide with this transfer.
- **Flow control.** Holding i_ready low stalls the output. o_data, o_sat and o_last stay stable until accepted.
- **i_enable low.** o_valid=0 and o_ready=0. Registers and lane counter hold their values; no handshakes occur. Operation resumes exactly where it stopped.
- **Reset (asynchronous, may assert mid-block).**
  - Both full flags cleared, lane=0, stored data and sat bits cleared.
  - Outputs during and after reset: o_valid=0, o_data=0, o_sat=0, o_last=0, o_ready=0 while i_reset=1.
  - A partially emitted block is discarded.

## Timing

- **Latency.** A block accepted at edge k (ACTIVE empty) gives o_valid=1 with lane 0 in the cycle after edge k. Lanes 1,2,3 follow on consecutive cycles while i_ready=1.
- **Throughput.** A new block every 4 cycles gives a continuous o_valid=1, with no idle cycle between the lane 3 of one block and the lane 0 of the next.
- **Buffering.** At most 2 blocks are buffered. o_ready drops in the cycle after NEXT fills and rises in the cycle after the NEXT→ACTIVE transfer.
- **Release from reset.** o_ready=1 in the first cycle after i_reset deasserts, provided i_enable=1.

## Test plan

- **Rounding** (SHIFT=11, NB 19→8). Lanes = {1023, 1024, -1024, -1025}. Required: o_data = 0, 1, 0, -1 on 4 consecutive cycles; o_sat=0 throughout; o_last only on the 4th cycle.
- **Saturation.** Lanes = {262143, -262144, 2048, -2048}. Required: o_data = 127 (o_sat=1), -128 (o_sat=0), 1, -1.
- **Back-to-back streaming.** Present a new block every 4 cycles, with i_ready=1, for 8 blocks. Required: o_valid high for 32 consecutive cycles, lane order preserved, o_last every 4th cycle.
- **Backpressure.**
  - Hold i_ready=0 for 10 cycles while 3 blocks are offered. Required: o_ready drops after 2 blocks are accepted; o_data remains lane 0 of block 1 throughout the stall.
  - Then release i_ready. Required: all 8 samples appear in order and the third block is accepted afterwards.
- **Enable freeze.** Deassert i_enable after lane 1 for 5 cycles. Required: o_valid=0 and o_ready=0 for those 5 cycles; on re-enable, output resumes at lane 2.
- **Reset mid-block.** Assert i_reset asynchronously during lane 2. Required: o_valid, o_data and o_last are 0 immediately; after release, no residual samples appear, and a fresh block is emitted from its lane 0.

Source files
------------

// File: rtl/fir_output_serializer_if.sv
// fir_output_serializer_if
//   Bundles the block-input and sample-output handshakes of the FIR output
//   serializer.
//   master : upstream/downstream side (drives lane data, i_valid, i_ready)
//   slave  : the serializer itself (drives o_ready, o_data, o_valid, o_sat, o_last)
interface fir_output_serializer_if #(
  parameter int NB_DATA_IN  = 19,
  parameter int NB_DATA_OUT = 8
);
  logic signed [NB_DATA_IN-1:0]  i_data_0;
  logic signed [NB_DATA_IN-1:0]  i_data_1;
  logic signed [NB_DATA_IN-1:0]  i_data_2;
  logic signed [NB_DATA_IN-1:0]  i_data_3;
  logic                          i_valid;
  logic                          o_ready;
  logic signed [NB_DATA_OUT-1:0] o_data;
  logic                          o_valid;
  logic                          i_ready;
  logic                          o_sat;
  logic                          o_last;

  modport master (
    output i_data_0, i_data_1, i_data_2, i_data_3, i_valid, i_ready,
    input  o_ready, o_data, o_valid, o_sat, o_last
  );

  modport slave (
    input  i_data_0, i_data_1, i_data_2, i_data_3, i_valid, i_ready,
    output o_ready, o_data, o_valid, o_sat, o_last
  );
endinterface

// File: rtl/fir_output_serializer.sv
// fir_output_serializer
//   Takes a 4-lane block from the parallel FIR, requantizes each lane
//   (round-half-up, saturate) on capture and streams the lanes out one per
//   clock in order 0..3. Two block registers (ACTIVE, NEXT) let a new block
//   arrive every 4 cycles without bubbles.
// Ports:
//   clock    : rising-edge clock
//   i_reset  : asynchronous active-high reset
//   i_enable : global enable; low freezes all state and blocks handshakes
//   bus      : slave side of fir_output_serializer_if (block in, sample out)
//
// Buffer occupancy:
//   act_full | nxt_full | meaning
//   0        | 0        | empty, accepting
//   1        | 0        | emitting ACTIVE, accepting into NEXT
//   1        | 1        | emitting ACTIVE, NEXT waiting, not accepting
module fir_output_serializer #(
  parameter int NB_DATA_IN  = 19,
  parameter int NB_DATA_OUT = 8,
  parameter int SHIFT       = 11
) (
  input  logic clock,
  input  logic i_reset,
  input  logic i_enable,
  fir_output_serializer_if.slave bus
);

  localparam int NBW     = NB_DATA_IN + 1;
  localparam int RND_POS = (SHIFT > 0) ? SHIFT - 1 : 0;
  localparam logic signed [NBW-1:0] RND   = (SHIFT > 0) ? (NBW'(1) << RND_POS) : '0;
  localparam logic signed [NBW-1:0] MAX_V = NBW'((1 << (NB_DATA_OUT - 1)) - 1);
  localparam logic signed [NBW-1:0] MIN_V = -MAX_V - NBW'(1);

  // Stored lane word: {sat, data}
  typedef logic [NB_DATA_OUT:0] lane_t;

  function automatic lane_t requant(input logic signed [NB_DATA_IN-1:0] x);
    logic signed [NBW-1:0] t;
    logic signed [NBW-1:0] y;
    lane_t r;
    t = $signed({x[NB_DATA_IN-1], x}) + RND;
    y = t >>> SHIFT;
    if (y > MAX_V)      r = {1'b1, MAX_V[NB_DATA_OUT-1:0]};
    else if (y < MIN_V) r = {1'b1, MIN_V[NB_DATA_OUT-1:0]};
    else                r = {1'b0, y[NB_DATA_OUT-1:0]};
    return r;
  endfunction

  logic [3:0][NB_DATA_OUT:0] act_q, act_d;
  logic [3:0][NB_DATA_OUT:0] nxt_q, nxt_d;
  logic [3:0][NB_DATA_OUT:0] cap;
  logic                      act_full_q, act_full_d;
  logic                      nxt_full_q, nxt_full_d;
  logic [1:0]                lane_q, lane_d;
  logic                      in_hs, out_hs, finishing;

  assign bus.o_valid = act_full_q & i_enable;
  assign bus.o_ready = ~nxt_full_q & i_enable & ~i_reset;
  assign bus.o_data  = act_q[lane_q][NB_DATA_OUT-1:0];
  assign bus.o_sat   = act_q[lane_q][NB_DATA_OUT];
  assign bus.o_last  = (lane_q == 2'd3);

  assign in_hs     = bus.i_valid & bus.o_ready;
  assign out_hs    = bus.o_valid & bus.i_ready;
  assign finishing = out_hs & (lane_q == 2'd3);

  always_comb begin
    cap[0] = requant(bus.i_data_0);
    cap[1] = requant(bus.i_data_1);
    cap[2] = requant(bus.i_data_2);
    cap[3] = requant(bus.i_data_3);
  end

  always_comb begin
    act_d      = act_q;
    nxt_d      = nxt_q;
    act_full_d = act_full_q;
    nxt_full_d = nxt_full_q;
    lane_d     = lane_q;

    if (out_hs) begin
      // 2-bit counter wraps 3 -> 0 on its own
      lane_d = lane_q + 2'd1;
      if (finishing) begin
        act_full_d = 1'b0;
        if (nxt_full_q) begin
          act_d      = nxt_q;
          act_full_d = 1'b1;
          nxt_full_d = 1'b0;
        end
      end
    end

    // in_hs implies NEXT is empty, so it can never race the NEXT->ACTIVE move
    if (in_hs) begin
      if (!act_full_q || (finishing && !nxt_full_q)) begin
        act_d      = cap;
        act_full_d = 1'b1;
      end else begin
        nxt_d      = cap;
        nxt_full_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or posedge i_reset) begin
    if (i_reset) begin
      act_q      <= '0;
      nxt_q      <= '0;
      act_full_q <= 1'b0;
      nxt_full_q <= 1'b0;
      lane_q     <= 2'd0;
    end else begin
      act_q      <= act_d;
      nxt_q      <= nxt_d;
      act_full_q <= act_full_d;
      nxt_full_q <= nxt_full_d;
      lane_q     <= lane_d;
    end
  end

endmodule

// File: tb/tb_fir_output_serializer.sv
module tb_fir_output_serializer;

  localparam int NB_DATA_IN  = 19;
  localparam int NB_DATA_OUT = 8;
  localparam int SHIFT       = 11;
  localparam int OUT_MAX     = (1 << (NB_DATA_OUT - 1)) - 1;
  localparam int OUT_MIN     = -(1 << (NB_DATA_OUT - 1));

  logic clock = 1'b0;
  logic i_reset = 1'b0;
  logic i_enable = 1'b1;

  fir_output_serializer_if #(.NB_DATA_IN(NB_DATA_IN), .NB_DATA_OUT(NB_DATA_OUT)) bus ();

  fir_output_serializer #(
    .NB_DATA_IN(NB_DATA_IN), .NB_DATA_OUT(NB_DATA_OUT), .SHIFT(SHIFT)
  ) dut (
    .clock(clock), .i_reset(i_reset), .i_enable(i_enable), .bus(bus)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: expected output samples in emission order.
  typedef struct {int data; bit sat; bit last;} samp_t;
  samp_t q[$];

  function automatic samp_t rq(input int x, input bit last);
    samp_t s;
    int t;
    t = (SHIFT > 0) ? x + (1 << (SHIFT - 1)) : x;
    s.data = t >>> SHIFT;
    s.sat  = 1'b0;
    s.last = last;
    if (s.data > OUT_MAX) begin s.data = OUT_MAX; s.sat = 1'b1; end
    else if (s.data < OUT_MIN) begin s.data = OUT_MIN; s.sat = 1'b1; end
    return s;
  endfunction

  bit acc_flag = 0;
  int run_len = 0;
  int max_run = 0;
  bit ev, er;
  int blocks;

  // Per-cycle comparison against the model; also advances the model for the
  // coming rising edge. Blocks held = samples outstanding rounded up to blocks.
  always @(negedge clock) begin
    if (i_reset) begin
      q.delete();
      acc_flag = 0;
      run_len  = 0;
      check("rst_valid", int'(bus.o_valid), 0);
      check("rst_ready", int'(bus.o_ready), 0);
      check("rst_data",  int'(bus.o_data), 0);
      check("rst_sat",   int'(bus.o_sat), 0);
      check("rst_last",  int'(bus.o_last), 0);
    end else begin
      blocks = (q.size() + 3) / 4;
      ev = (q.size() > 0) && i_enable;
      er = (blocks < 2) && i_enable;
      check("o_valid", int'(bus.o_valid), int'(ev));
      check("o_ready", int'(bus.o_ready), int'(er));
      if (ev) begin
        check("o_data", int'(bus.o_data), q[0].data);
        check("o_sat",  int'(bus.o_sat),  int'(q[0].sat));
        check("o_last", int'(bus.o_last), int'(q[0].last));
      end
      if (ev && bus.o_valid) run_len++; else run_len = 0;
      if (run_len > max_run) max_run = run_len;
      if (ev && bus.i_ready) void'(q.pop_front());
      acc_flag = er && bus.i_valid;
      if (acc_flag) begin
        q.push_back(rq(int'(bus.i_data_0), 1'b0));
        q.push_back(rq(int'(bus.i_data_1), 1'b0));
        q.push_back(rq(int'(bus.i_data_2), 1'b0));
        q.push_back(rq(int'(bus.i_data_3), 1'b1));
      end
    end
  end

  task automatic drive_block(input int d0, input int d1, input int d2, input int d3);
    bus.i_data_0 = NB_DATA_IN'(d0);
    bus.i_data_1 = NB_DATA_IN'(d1);
    bus.i_data_2 = NB_DATA_IN'(d2);
    bus.i_data_3 = NB_DATA_IN'(d3);
  endtask

  task automatic send_block(input int d0, input int d1, input int d2, input int d3);
    bit done;
    done = 0;
    drive_block(d0, d1, d2, d3);
    bus.i_valid = 1'b1;
    for (int n = 0; n < 200 && !done; n++) begin
      @(posedge clock); #1;
      done = acc_flag;
    end
    if (!done) check("send_timeout", 0, 1);
    bus.i_valid = 1'b0;
  endtask

  task automatic drain();
    bit done;
    done = 0;
    for (int n = 0; n < 500 && !done; n++) begin
      if (q.size() == 0) done = 1;
      else begin @(posedge clock); #1; end
    end
    if (!done) check("drain_timeout", 0, 1);
    @(posedge clock); #1;
  endtask

  function automatic int rand_sample();
    logic signed [NB_DATA_IN-1:0] v;
    if ($urandom_range(0, 1) == 0) v = NB_DATA_IN'($urandom);
    else v = NB_DATA_IN'(int'($urandom_range(0, 524287)) - 262144) >>> 2;
    return int'(v);
  endfunction

  int rnd_exp [4] = '{0, 1, 0, -1};
  int sat_exp [4] = '{127, -128, 1, -1};
  int sat_flg [4] = '{1, 0, 0, 0};

  initial begin
    #400000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.i_valid = 1'b0;
    bus.i_ready = 1'b1;
    drive_block(0, 0, 0, 0);
    #1 i_reset = 1'b1;
    repeat (2) @(posedge clock);
    #1 i_reset = 1'b0;

    // Rounding
    send_block(1023, 1024, -1024, -1025);
    for (int l = 0; l < 4; l++) begin
      @(negedge clock); #1;
      check("rnd_data", int'(bus.o_data), rnd_exp[l]);
      check("rnd_sat",  int'(bus.o_sat), 0);
      check("rnd_last", int'(bus.o_last), (l == 3) ? 1 : 0);
    end
    drain();

    // Saturation
    send_block(262143, -262144, 2048, -2048);
    for (int l = 0; l < 4; l++) begin
      @(negedge clock); #1;
      check("sat_data", int'(bus.o_data), sat_exp[l]);
      check("sat_flag", int'(bus.o_sat), sat_flg[l]);
    end
    drain();

    // Back-to-back streaming
    max_run = 0;
    for (int b = 0; b < 8; b++)
      send_block(rand_sample(), rand_sample(), rand_sample(), rand_sample());
    drain();
    check("stream_run", max_run, 32);

    // Backpressure
    bus.i_ready = 1'b0;
    fork
      begin
        for (int b = 0; b < 3; b++)
          send_block(rand_sample(), rand_sample(), rand_sample(), rand_sample());
      end
      begin
        repeat (10) @(posedge clock);
        #1;
        check("bp_ready_low", int'(bus.o_ready), 0);
        check("bp_q_blocks", q.size(), 8);
        bus.i_ready = 1'b1;
      end
    join
    drain();

    // Enable freeze after lane 1
    send_block(rand_sample(), rand_sample(), rand_sample(), rand_sample());
    repeat (2) @(posedge clock);
    #1 i_enable = 1'b0;
    repeat (5) @(posedge clock);
    #1 i_enable = 1'b1;
    drain();

    // Reset mid-block during lane 2
    send_block(1 << 12, 2 << 12, 3 << 12, 4 << 12);
    repeat (2) @(posedge clock);
    #2 i_reset = 1'b1;
    #1;
    check("rst_imm_valid", int'(bus.o_valid), 0);
    check("rst_imm_data",  int'(bus.o_data), 0);
    check("rst_imm_last",  int'(bus.o_last), 0);
    @(posedge clock);
    #1 i_reset = 1'b0;
    send_block(5 << 11, 6 << 11, 7 << 11, 8 << 11);
    drain();

    // Randomized traffic with occasional enable drops and resets
    for (int c = 0; c < 600; c++) begin
      @(posedge clock); #1;
      if (i_reset) i_reset = 1'b0;
      else if ($urandom_range(0, 99) == 0) i_reset = 1'b1;
      i_enable    = ($urandom_range(0, 9) != 0);
      bus.i_ready = ($urandom_range(0, 3) != 0);
      bus.i_valid = ($urandom_range(0, 4) < 3);
      drive_block(rand_sample(), rand_sample(), rand_sample(), rand_sample());
    end
    i_reset     = 1'b0;
    i_enable    = 1'b1;
    bus.i_ready = 1'b1;
    bus.i_valid = 1'b0;
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
